// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if : bundle between the decode stage and the ID/EX pipeline register.
//
//   id_*  : decoded control, register indices, operands, immediate and PC of
//           the instruction currently in ID (driven by the decode side).
//   ex_*  : registered copies presented to EX, plus ex_valid.
//
// Modports
//   master : decode side (drives id_*, observes ex_*)
//   slave  : id_ex_stage (consumes id_*, drives ex_*)
// ---------------------------------------------------------------------------
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // Decode side
  logic [2:0]        id_aluop;
  logic              id_alusrc;
  logic [1:0]        id_pcsrc;
  logic [1:0]        id_memtoreg;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_branch;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [XLEN-1:0]   id_rdata1;
  logic [XLEN-1:0]   id_rdata2;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;

  // Execute side
  logic [2:0]        ex_aluop;
  logic              ex_alusrc;
  logic [1:0]        ex_pcsrc;
  logic [1:0]        ex_memtoreg;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_branch;
  logic              ex_use_rs1;
  logic              ex_use_rs2;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_rdata1;
  logic [XLEN-1:0]   ex_rdata2;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_valid;

  modport master (
    output id_aluop, id_alusrc, id_pcsrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_branch, id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc,
    input  ex_aluop, ex_alusrc, ex_pcsrc, ex_memtoreg, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_use_rs1, ex_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_rdata1, ex_rdata2, ex_imm, ex_pc, ex_valid
  );

  modport slave (
    input  id_aluop, id_alusrc, id_pcsrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_branch, id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc,
    output ex_aluop, ex_alusrc, ex_pcsrc, ex_memtoreg, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_use_rs1, ex_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_rdata1, ex_rdata2, ex_imm, ex_pc, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register of the 5-stage RV32 pipeline with the
// load-use hazard detector.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : id_* in from decode, ex_* / ex_valid out to EX
//   flush_i         : branch/jump taken in EX, kill the instruction entering EX
//   hold_i          : downstream stall, freeze this register
//   hazard_stall_o  : load-use detected, freeze PC and IF/ID (combinational)
//   perf_lu_cnt     : (IDEX_PERF_CNT_EN only) saturating count of hazard bubbles
//   perf_flush_cnt  : (IDEX_PERF_CNT_EN only) saturating count of flush edges
//
// Optional build macro: IDEX_PERF_CNT_EN adds the two performance counters.
//
// Handshake: there is no valid/ready pair here. Each rising edge either loads
// ID (ex_valid=1), loads a bubble (everything 0), or holds; priority is
// flush_i > hold_i > hazard > load. flush_i/hold_i only steer the next-state
// mux, so they have no combinational path to ex_*.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_if.slave       bus,
  input  logic         flush_i,
  input  logic         hold_i,
`ifdef IDEX_PERF_CNT_EN
  output logic [15:0]  perf_lu_cnt,
  output logic [15:0]  perf_flush_cnt,
`endif
  output logic         hazard_stall_o
);

  typedef struct packed {
    logic [2:0]        aluop;
    logic              alusrc;
    logic [1:0]        pcsrc;
    logic [1:0]        memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              valid;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, id_word;
  logic    load_use;

  // Incoming instruction, marked valid, in register layout.
  always_comb begin
    id_word          = '0;
    id_word.aluop    = bus.id_aluop;
    id_word.alusrc   = bus.id_alusrc;
    id_word.pcsrc    = bus.id_pcsrc;
    id_word.memtoreg = bus.id_memtoreg;
    id_word.regwrite = bus.id_regwrite;
    id_word.memread  = bus.id_memread;
    id_word.memwrite = bus.id_memwrite;
    id_word.branch   = bus.id_branch;
    id_word.use_rs1  = bus.id_use_rs1;
    id_word.use_rs2  = bus.id_use_rs2;
    id_word.rs1      = bus.id_rs1;
    id_word.rs2      = bus.id_rs2;
    id_word.rd       = bus.id_rd;
    id_word.rdata1   = bus.id_rdata1;
    id_word.rdata2   = bus.id_rdata2;
    id_word.imm      = bus.id_imm;
    id_word.pc       = bus.id_pc;
    id_word.valid    = 1'b1;
  end

  // A load in EX whose destination the ID instruction actually reads. x0 is
  // excluded because it is never written.
  always_comb begin
    load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));
  end

  // Flush kills the ID instruction anyway, and under hold nothing advances,
  // so neither case needs upstream frozen.
  assign hazard_stall_o = load_use && !flush_i && !hold_i;

  always_comb begin
    ex_d = ex_q;
    if (flush_i)             ex_d = '0;
    else if (hold_i)         ex_d = ex_q;
    else if (hazard_stall_o) ex_d = '0;
    else                     ex_d = id_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_pcsrc    = ex_q.pcsrc;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_use_rs1  = ex_q.use_rs1;
  assign bus.ex_use_rs2  = ex_q.use_rs2;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rdata1   = ex_q.rdata1;
  assign bus.ex_rdata2   = ex_q.rdata2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_valid    = ex_q.valid;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // hazard_stall_o is already masked by flush/hold, so it is high exactly on
  // the edges that load a hazard bubble.
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_stall_o && (lu_cnt_q != 16'hFFFF)) lu_cnt_d    = lu_cnt_q + 16'd1;
    if (flush_i && (flush_cnt_q != 16'hFFFF))     flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_lu_cnt    = lu_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int BW = 158;  // width of the packed EX-side bundle below
  localparam int NV = 22;

  logic clk;
  logic rst_n;
  logic flush_i;
  logic hold_i;
  logic hazard_stall_o;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0] perf_lu_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  id_ex_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush_i        (flush_i),
    .hold_i         (hold_i),
`ifdef IDEX_PERF_CNT_EN
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .hazard_stall_o (hazard_stall_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  // Secondary id_* fields are derived from rd/rdata1 so every ex_* output
  // carries a distinct, predictable value. exp_src names the table row whose
  // ID instruction must be in EX after the edge (-1 = bubble).
  typedef struct {
    logic        flush, hold, use1, use2, mr, mw, rw;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  aluop;
    logic [31:0] rdata1;
    logic        exp_haz;
    int          exp_src;
  } vec_t;

  vec_t vecs [NV];
  logic [BW-1:0] exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(logic flush, logic hold, logic use1, logic use2,
                              logic mr, logic mw, logic rw, logic [4:0] rs1,
                              logic [4:0] rs2, logic [4:0] rd, logic [2:0] aluop,
                              logic [31:0] rdata1, logic exp_haz, int exp_src);
    vec_t v;
    v.flush = flush; v.hold = hold; v.use1 = use1; v.use2 = use2;
    v.mr = mr; v.mw = mw; v.rw = rw; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.aluop = aluop; v.rdata1 = rdata1; v.exp_haz = exp_haz; v.exp_src = exp_src;
    return v;
  endfunction

  function automatic logic [BW-1:0] bundle_of(vec_t s);
    return {s.aluop, s.rd[0], s.rd[1:0], s.rd[2:1], s.rw, s.mr, s.mw, s.rd[3],
            s.use1, s.use2, s.rs1, s.rs2, s.rd, s.rdata1, ~s.rdata1,
            s.rdata1 ^ 32'h00FF_00FF, s.rdata1 + 32'h0000_1000, 1'b1};
  endfunction

  function automatic logic [BW-1:0] ex_actual();
    return {bus.ex_aluop, bus.ex_alusrc, bus.ex_pcsrc, bus.ex_memtoreg,
            bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch,
            bus.ex_use_rs1, bus.ex_use_rs2, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
            bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_pc, bus.ex_valid};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(vec_t s);
    flush_i         = s.flush;
    hold_i          = s.hold;
    bus.id_aluop    = s.aluop;
    bus.id_alusrc   = s.rd[0];
    bus.id_pcsrc    = s.rd[1:0];
    bus.id_memtoreg = s.rd[2:1];
    bus.id_regwrite = s.rw;
    bus.id_memread  = s.mr;
    bus.id_memwrite = s.mw;
    bus.id_branch   = s.rd[3];
    bus.id_use_rs1  = s.use1;
    bus.id_use_rs2  = s.use2;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_rd       = s.rd;
    bus.id_rdata1   = s.rdata1;
    bus.id_rdata2   = ~s.rdata1;
    bus.id_imm      = s.rdata1 ^ 32'h00FF_00FF;
    bus.id_pc       = s.rdata1 + 32'h0000_1000;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_ex(string name);
    logic [BW-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, ex_actual(), e);
    end
  endtask

  vec_t lw7, use7, nop;

  initial begin
    // Load-use sequence vectors used by the hand-written sections.
    lw7  = mk(0,0,0,0,1,0,1, 5'd0, 5'd0, 5'd7, 3'b000, 32'h0000_0400, 0, 0);
    use7 = mk(0,0,1,0,0,0,1, 5'd7, 5'd0, 5'd13,3'b010, 32'h0000_0500, 0, 0);
    nop  = mk(0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0, 0, 0);

    //            fl ho u1 u2 mr mw rw rs1   rs2   rd     aluop   rdata1        haz src
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd5,  3'b011, 32'h0000_1234, 0,  0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd7,  3'b000, 32'h0000_0100, 0,  1);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd8,  3'b001, 32'h0000_0055, 1, -1);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd8,  3'b001, 32'h0000_0055, 0,  3);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0,  3'b000, 32'h0000_0022, 0,  4);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd3,  3'b100, 32'h0000_0033, 0,  5);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd7,  3'b000, 32'h0000_0200, 0,  6);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 1, 5'd1, 5'd7, 5'd9,  3'b101, 32'h0000_0099, 0,  7);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd7,  3'b000, 32'h0000_0210, 0,  8);
    vecs[9]  = mk(0, 0, 1, 1, 0, 1, 0, 5'd2, 5'd7, 5'd0,  3'b000, 32'hDEAD_0000, 1, -1);
    vecs[10] = mk(0, 0, 1, 1, 0, 1, 0, 5'd2, 5'd7, 5'd0,  3'b000, 32'hDEAD_0000, 0, 10);
    vecs[11] = mk(1, 0, 1, 1, 0, 1, 0, 5'd2, 5'd3, 5'd0,  3'b000, 32'hBEEF_0000, 0, -1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd4,  3'b110, 32'h0000_0077, 0, 12);
    vecs[13] = mk(1, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd6,  3'b111, 32'h0000_0066, 0, -1);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd7,  3'b000, 32'h0000_0300, 0, 14);
    vecs[15] = mk(0, 1, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd10, 3'b001, 32'h0000_0A00, 0, 14);
    vecs[16] = mk(0, 1, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd11, 3'b010, 32'h0000_0B00, 0, 14);
    vecs[17] = mk(0, 1, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd12, 3'b011, 32'h0000_0C00, 0, 14);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd12, 3'b011, 32'h0000_0C00, 1, -1);
    vecs[19] = mk(0, 0, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd12, 3'b011, 32'h0000_0C00, 0, 19);
    vecs[20] = mk(0, 0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd7,  3'b000, 32'h0000_0500, 0, 20);
    vecs[21] = mk(1, 0, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd14, 3'b001, 32'h0000_0E00, 0, -1);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(nop);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ex_bundle", ex_actual(), '0);
    check("reset_hazard", BW'(hazard_stall_o), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp_src < 0 ? '0 : bundle_of(vecs[vecs[i].exp_src]));
      #1;
      check($sformatf("hazard[%0d]", i), BW'(hazard_stall_o), BW'(vecs[i].exp_haz));
      @(posedge clk);
      #1;
      check_ex($sformatf("ex_bundle[%0d]", i));
      @(negedge clk);
    end

    // ---------------- reset asserted mid-stall ----------------
    drive(lw7);
    @(posedge clk);
    @(negedge clk);
    drive(use7);
    #1;
    check("midstall_hazard_before_reset", BW'(hazard_stall_o), BW'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check("midstall_reset_ex_clears", ex_actual(), '0);
    check("midstall_reset_hazard", BW'(hazard_stall_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(bundle_of(use7));
    @(posedge clk);
    #1;
    check_ex("after_reset_first_load");
    @(negedge clk);

`ifdef IDEX_PERF_CNT_EN
    // ---------------- performance counters ----------------
    rst_n = 1'b0;
    #1;
    check("perf_lu_after_reset", BW'(perf_lu_cnt), '0);
    check("perf_flush_after_reset", BW'(perf_flush_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(lw7);  @(posedge clk); @(negedge clk);
      drive(use7); @(posedge clk); @(negedge clk);  // bubble
      @(posedge clk); @(negedge clk);              // held instruction loads
    end
    drive(nop);
    flush_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("perf_lu_two_hazards", BW'(perf_lu_cnt), BW'(16'd2));
    check("perf_flush_three", BW'(perf_flush_cnt), BW'(16'd3));
    flush_i = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    check("perf_flush_saturated", BW'(perf_flush_cnt), BW'(16'hFFFF));
    @(posedge clk);
    @(negedge clk);
    check("perf_flush_stays_saturated", BW'(perf_flush_cnt), BW'(16'hFFFF));
    flush_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("perf_lu_after_pulse", BW'(perf_lu_cnt), '0);
    check("perf_flush_after_pulse", BW'(perf_flush_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 pipeline, directly downstream of the decode-stage control unit.
- Captures the control bundle (aluop, alusrc, pcsrc, memtoreg, regwrite, memread, memwrite, branch), operands, immediate, PC and register indices each cycle.
- Contains the load-use hazard detector. Inserts bubbles on load-use hazards and on branch/jump flush, and holds its contents on a downstream stall.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_aluop  in  3  decoded ALU op
- id_alusrc  in  1  ALU B-source select
- id_pcsrc  in  2  next-PC select
- id_memtoreg  in  2  writeback select
- id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded controls
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_rdata1, id_rdata2, id_imm, id_pc  in  XLEN each  operands, immediate, PC
- flush_i  in  1  branch/jump taken in EX; kill the instruction entering EX
- hold_i  in  1  downstream stall; freeze the register
- ex_* (one per id_* control/data/index above)  out  same widths  registered copies
- ex_valid  out  1  EX holds a real instruction
- hazard_stall_o  out  1  load-use detected; freeze PC and IF/ID

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs and ex_valid are 0. hazard_stall_o evaluates to 0 because ex_valid=0.
- hazard_stall_o is combinational. It is 1 iff all of the following hold:
  - ex_valid and ex_memread are 1;
  - ex_rd != 0;
  - (id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd).
- hazard_stall_o is forced to 0 while flush_i=1 or hold_i=1.
- Next-state priority on each rising clk:
  1. flush_i=1: load a bubble.
  2. else hold_i=1: keep all registers unchanged.
  3. else hazard_stall_o=1: load a bubble.
  4. else: load all id_* inputs and set ex_valid=1.
- Bubble definition:
  - All control outputs 0 (ex_aluop=0, ex_pcsrc=0, ex_memtoreg=0, ex_regwrite=ex_memread=ex_memwrite=ex_branch=ex_alusrc=0).
  - ex_valid=0.
  - Indices, data, imm and pc cleared to 0.
- Latency: one cycle from id_* to ex_*. A load-use hazard costs exactly one bubble. On the following cycle EX holds the bubble, so hazard_stall_o drops without any extra state.
- rd=x0 never triggers a hazard. A store or branch whose rs2 matches a load rd does trigger one when id_use_rs2=1.
- Simultaneous flush_i and hold_i: flush wins; a bubble is loaded.
- Reset asserted mid-stall: contents clear immediately. After deassertion the first edge loads normally.
- No combinational path from flush_i/hold_i to ex_* outputs.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds outputs perf_lu_cnt[15:0] and perf_flush_cnt[15:0], both 16-bit saturating counters reset to 0.
  - perf_lu_cnt increments on each edge where a hazard bubble is loaded.
  - perf_flush_cnt increments on each edge where flush_i=1.
  - Each counter saturates at 16'hFFFF.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then pass-through: id_rd=5, id_regwrite=1, id_aluop=3'b011, id_rdata1=32'h1234 -> one edge later ex_rd=5, ex_regwrite=1, ex_aluop=3'b011, ex_rdata1=32'h1234, ex_valid=1.
- Load-use on rs1:
  - Stimulus: LW in EX (ex_memread=1, ex_rd=7); ID presents id_rs1=7, id_use_rs1=1.
  - Required: hazard_stall_o=1; next edge loads a bubble (ex_valid=0, ex_regwrite=0); hazard_stall_o=0 on the following cycle; the held ID instruction loads on the next edge.
- x0 and unused-operand cases:
  - ex_rd=0 with ex_memread=1 and id_rs1=0 -> hazard_stall_o=0.
  - id_rs2=7 with id_use_rs2=0 -> hazard_stall_o=0.
- flush_i=1 with valid SW at ID (id_memwrite=1) -> next edge ex_memwrite=0, ex_valid=0. flush_i=1 with hold_i=1 -> bubble.
- hold_i=1 for 3 cycles with changing id_* inputs -> ex_* outputs constant. hazard_stall_o=0 throughout, even with a matching load in EX.
- With IDEX_PERF_CNT_EN: 2 load-use hazards and 3 flushes -> perf_lu_cnt=2, perf_flush_cnt=3. Preload 16'hFFFF and flush again -> perf_flush_cnt stays 16'hFFFF. rst_n pulse mid-run -> both counters read 0.
